// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: operation encodings and FSM state type.
package serial_alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SMAX = 2'b10;
  localparam logic [1:0] OP_SMIN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_alu_fa_bit.sv
// One-bit full adder used as the serial datapath of serial_alu.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_alu.sv
// Bit-serial signed ALU: ADD/SUB/SMAX/SMIN, one operand bit per cycle LSB-first
// through a single full adder, WIDTH cycles per operation.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned IDX_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-2:0] sr_q, sr_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  logic             fa_x, fa_y, fa_sum, fa_cout;
  logic [WIDTH-1:0] diff;
  logic             ovf_int, a_lt_b, last_bit;

  // SUB/compare use a + ~b + 1: invert b here, carry register preloaded with 1.
  assign fa_x = a_q[cnt_q[IDX_W-1:0]];
  assign fa_y = b_q[cnt_q[IDX_W-1:0]] ^ (op_q != OP_ADD);

  fa_bit u_fa (
    .x    (fa_x),
    .y    (fa_y),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // sr_q holds the completed low sum bits; the MSB joins on the final cycle.
  assign diff     = {fa_sum, sr_q};
  assign ovf_int  = carry_q ^ fa_cout;
  assign a_lt_b   = diff[WIDTH-1] ^ ovf_int;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sr_d     = sr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          carry_d = (op != OP_ADD);
          sr_d    = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        carry_d = fa_cout;
        sr_d    = diff[WIDTH-1:1];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
          case (op_q)
            OP_SMAX: begin result_d = a_lt_b ? b_q : a_q; ovf_d = 1'b0; end
            OP_SMIN: begin result_d = a_lt_b ? a_q : b_q; ovf_d = 1'b0; end
            default: begin result_d = diff;               ovf_d = ovf_int; end
          endcase
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sr_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sr_q     <= sr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: doc/serial_alu.md
SERIAL_ALU -- requirements
Module: serial_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 Port: op  input  2  operation: 00 ADD, 01 SUB (a-b), 10 SMAX, 11 SMIN (two's-complement signed).
REQ-006 Port: a  input  WIDTH  signed operand A, captured with start.
REQ-007 Port: b  input  WIDTH  signed operand B, captured with start.
REQ-008 Port: busy  output  1  high while an operation is in SHIFT state.
REQ-009 Port: done  output  1  one-cycle pulse: result/overflow newly valid.
REQ-010 Port: result  output  WIDTH  registered result of last completed operation.
REQ-011 Port: overflow  output  1  registered signed-overflow flag of last completed operation.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; no other reachable states.
REQ-013 IDLE: start=1 at edge E0 SHALL capture a, b, op into internal registers, clear bit counter, load carry with 0 for ADD and 1 otherwise, go to SHIFT.
REQ-014 IDLE with start=0 SHALL remain in IDLE; outputs unchanged except done=0.
REQ-015 SHIFT SHALL process one bit per cycle LSB-first via a 1-bit full adder: x=a[i], y=b[i] XOR (op!=ADD), cin=carry register.
REQ-016 Sum bits SHALL shift into a WIDTH-bit shift register; carry register updated with cout each SHIFT cycle.
REQ-017 Carry-in of bit WIDTH-1 SHALL be retained for overflow = cin(MSB) XOR cout(MSB).
REQ-018 After exactly WIDTH SHIFT cycles (edges E0+1..E0+WIDTH), FSM SHALL enter DONE at edge E0+WIDTH with result/overflow/done registered at that edge.
REQ-019 ADD/SUB: result = WIDTH-bit sum/difference (wrap-around modulo 2^WIDTH), overflow per REQ-017.
REQ-020 SMAX/SMIN: a_lt_b = diff[WIDTH-1] XOR overflow_internal; SMAX result = a_lt_b ? b : a; SMIN result = a_lt_b ? a : b; overflow output = 0.
REQ-021 Equal operands under SMAX/SMIN SHALL return a.
REQ-022 done SHALL be 1 only in DONE state (exactly one cycle); DONE SHALL return to IDLE unconditionally.
REQ-023 busy SHALL be 1 exactly in SHIFT (WIDTH cycles per operation), 0 in IDLE and DONE.
REQ-024 start in SHIFT or DONE SHALL be ignored (not queued); captured operands not disturbed by input changes after E0.
REQ-025 Minimum start-to-start spacing SHALL be WIDTH+2 cycles (start accepted first IDLE cycle after DONE).
REQ-026 result and overflow SHALL hold their values from DONE until the next DONE.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, result=0, overflow=0, done=0, busy=0, clear carry, counter, shift and operand registers.
REQ-028 rst asserted mid-SHIFT or in DONE SHALL abort the operation with no done pulse; rst has priority over start.

Structure
REQ-029 Package serial_alu_pkg SHALL hold op encodings (OP_ADD, OP_SUB, OP_SMAX, OP_SMIN) and the FSM state type.
REQ-030 One sub-module fa_bit (1-bit full adder: x, y, cin -> sum, cout) SHALL be instantiated once; all other logic in serial_alu.
REQ-031 Bit counter width SHALL be $clog2(WIDTH)+1 bits.

Verification
REQ-032 WIDTH=4, ADD a=0x7 b=0x1 -> done 4 cycles after start edge, result=0x8, overflow=1; ADD 0x3+0x4 -> 0x7, overflow=0.
REQ-033 WIDTH=4, SUB a=0x8 (-8) b=0x1 -> result=0x7, overflow=1; SUB 0x2-0x5 -> 0xD, overflow=0.
REQ-034 WIDTH=4, SMAX a=0x8 b=0x7 -> 0x7; SMIN a=0x3 b=0xE -> 0xE; SMAX a=b=0x5 -> 0x5; overflow=0 in all.
REQ-035 WIDTH=8, ADD a=100 b=100 -> busy high 8 cycles, result=0xC8, overflow=1, done pulse width 1.
REQ-036 Start pulsed again at cycles 2 and DONE of an operation with different operands -> ignored, original result; start in following IDLE accepted.
REQ-037 rst asserted at 2nd SHIFT cycle -> busy=0, result=0, no done pulse; new operation afterwards completes correctly.
